hr_csr_bank: RTL and testbench
==============================

# hr_csr_bank

Parametrised control/status register bank for the HyperRAM test subsystem, sitting between the TL-UL register adapter (1-cycle access latency, byte enables) and the HyperBus controller and loopback tester. It generalises the fixed register set to NumRw read/write and NumRo read-only words. It adds:
- sticky write-1-to-clear status with a masked interrupt;
- single-cycle action strobes;
- a supervised action handshake with timeout.

## Interface
- AW, 7, register address width in bytes; 0x10 + 4*(NumRw+NumRo) must be ≤ 2^AW
- NumRw, 4, number of 32-bit RW words (≥1)
- NumRo, 4, number of 32-bit RO words (≥1)
- NumStatus, 4, external sticky status inputs (1..29)
- RwResetVal, all zero, packed NumRw*32 reset values, word i at [32i+31:32i]
- TimeoutCycles, 1024, max cycles an action may stay outstanding (≥4)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- reg_we_i  in  1  write strobe
- reg_re_i  in  1  read strobe
- reg_addr_i  in  AW  byte address
- reg_wdata_i  in  32  write data
- reg_be_i  in  4  byte enables
- reg_rdata_o  out  32  read data, 1 cycle after reg_re_i
- reg_error_o  out  1  access error, aligned with reg_rdata_o / write response
- rw_o  out  NumRw*32  RW word contents
- ro_i  in  NumRo*32  RO word sources
- status_i  in  NumStatus  level event inputs
- irq_o  out  1  registered interrupt
- action_o  out  2  one-cycle strobes: [0] write, [1] read
- action_idle_i  in  1  controller idle

## Operation
Address map (byte, word-aligned):
- 0x00 STATUS, W1C. Bit layout:
  - [0] action done
  - [1] action timeout
  - [2] action overrun
  - [3+k] status_i[k]
  - other bits read 0
- 0x04 IRQ_EN, RW, same bit layout; reset 0.
- 0x08 ACTION. Write uses wdata[1:0] when be[0]=1. Read returns {30'b0, busy, action_idle_i}.
- 0x10+4i: RW word i.
- 0x10+4(NumRw+j): RO word j, returns ro_i word j.

Write rules:
- Byte enables mask writes to RW words, IRQ_EN and STATUS clears.

Error rules (reg_error_o=1, no state change, read data 0):
- unmapped address
- reg_addr_i[1:0]≠0
- write to an RO word
- ACTION write with wdata[1:0]=2'b11

Sticky status:
- A bit is set on any cycle its source is 1: status_i[k] high, or an internal event.
- A bit is cleared by a W1C write.
- Set wins over clear in the same cycle.
- irq_o is the registered value of |(STATUS & IRQ_EN).

Action FSM:
- IDLE: an ACTION write with exactly one bit set goes to ISSUE. A write of 2'b00 is a no-op.
- ISSUE (1 cycle): action_o = written bit; then go to WAIT_BUSY.
- WAIT_BUSY: wait for action_idle_i=0, then go to WAIT_IDLE.
- WAIT_IDLE: wait for action_idle_i=1, then set done and return to IDLE.
- busy = state≠IDLE.
- Timeout:
  - A cycle counter starts at ISSUE.
  - If it reaches TimeoutCycles in WAIT_BUSY or WAIT_IDLE, set timeout and return to IDLE.
  - done is not set on timeout.
- A valid ACTION write while busy is ignored (no error) and sets overrun.

## Timing
- Writes update state at the clock edge of reg_we_i; rw_o and IRQ_EN change the cycle after.
- Reads: reg_rdata_o is registered and valid exactly one cycle after reg_re_i.
  - It is 0 on any cycle not following a read.
  - A read and a write to the same address in one cycle return the old value.
- action_o is high exactly one cycle: the cycle after the accepting ACTION write.
- The done/timeout bit is visible in STATUS the cycle after the FSM terminates; irq_o follows one cycle later.

Reset values:
- rw_o = RwResetVal
- STATUS = 0, IRQ_EN = 0
- reg_rdata_o = 0, reg_error_o = 0
- irq_o = 0, action_o = 0
- FSM = IDLE, counter = 0

Reset mid-action returns the FSM to IDLE with no strobe, and sets no done or timeout bit.

Counter width is $clog2(TimeoutCycles+1); it saturates and never wraps.

## Test plan
- Reset, then read 0x10 -> RwResetVal word 0. Write 0x12345678 with be=4'b0101 over 0 -> 0x00340078 on rw_o and on readback one cycle after reg_re_i.
- Hold status_i[0]=1 for 1 cycle, IRQ_EN=0x8 -> STATUS reads 0x8; irq_o rises 2 cycles after the input. W1C 0x8 while status_i[0]=1 -> bit stays set; W1C after the input drops -> STATUS=0, irq_o falls.
- ACTION write 0x1; controller drops idle for 5 cycles -> action_o=2'b01 for exactly one cycle, ACTION read bit1=1 while busy, STATUS[0]=1 afterwards.
- ACTION write 0x2 with action_idle_i stuck 1, TimeoutCycles=16 -> STATUS[1]=1 after 16 cycles, STATUS[0]=0, FSM idle.
- ACTION write during busy -> no second strobe, STATUS[2]=1. ACTION write 0x3 -> reg_error_o=1, no strobe.
- Read address 0x01, an unmapped address, and a write to an RO word -> reg_error_o=1, rdata 0, rw_o unchanged. Assert rst_i during WAIT_IDLE -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/hr_csr_bank.sv
// Control/status register bank for the HyperRAM test subsystem: RW/RO words,
// sticky W1C status with masked interrupt, and a supervised action handshake.
module hr_csr_bank #(
   parameter int unsigned         AW            = 7,
   parameter int unsigned         NumRw         = 4,
   parameter int unsigned         NumRo         = 4,
   parameter int unsigned         NumStatus     = 4,
   parameter logic [NumRw*32-1:0] RwResetVal    = '0,
   parameter int unsigned         TimeoutCycles = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 reg_we_i,
   input  logic                 reg_re_i,
   input  logic [AW-1:0]        reg_addr_i,
   input  logic [31:0]          reg_wdata_i,
   input  logic [3:0]           reg_be_i,
   output logic [31:0]          reg_rdata_o,
   output logic                 reg_error_o,
   output logic [NumRw*32-1:0]  rw_o,
   input  logic [NumRo*32-1:0]  ro_i,
   input  logic [NumStatus-1:0] status_i,
   output logic                 irq_o,
   output logic [1:0]           action_o,
   input  logic                 action_idle_i
);

   localparam int unsigned SW       = 3 + NumStatus;
   localparam int unsigned CW       = $clog2(TimeoutCycles + 1);
   localparam int unsigned NumWords = NumRw + NumRo;
   localparam int unsigned WordEnd  = 16 + 4 * NumWords;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_IDLE
   } state_e;

   logic [31:0]   addr_c, word_idx_c, bmask_c, wmask_c, rdata_c;
   logic          hit_status_c, hit_irqen_c, hit_action_c, hit_word_c, is_ro_c;
   logic          mapped_c, wr_err_c, wr_ok_c, act_req_c;
   logic          busy_c, waiting_c, tmo_hit_c, done_set_c, tmo_set_c, ovr_set_c;
   logic [CW-1:0] cnt_inc_c;
   logic [SW-1:0] set_c, clr_c;

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [1:0]    action_q;
   logic [31:0]   rw_q [NumRw];
   logic [SW-1:0] status_q, irqen_q;
   logic          irq_q, error_q;
   logic [31:0]   rdata_q;

   // Address decode; word_idx_c is only meaningful when hit_word_c is set
   assign addr_c       = 32'(reg_addr_i);
   assign hit_status_c = (addr_c == 32'h00);
   assign hit_irqen_c  = (addr_c == 32'h04);
   assign hit_action_c = (addr_c == 32'h08);
   assign hit_word_c   = (addr_c >= 32'h10) && (addr_c < 32'(WordEnd));
   assign word_idx_c   = (addr_c - 32'h10) >> 2;
   assign is_ro_c      = (word_idx_c >= 32'(NumRw));
   assign mapped_c     = (reg_addr_i[1:0] == 2'b00) &&
                         (hit_status_c || hit_irqen_c || hit_action_c || hit_word_c);

   assign bmask_c = {{8{reg_be_i[3]}}, {8{reg_be_i[2]}}, {8{reg_be_i[1]}}, {8{reg_be_i[0]}}};
   assign wmask_c = reg_wdata_i & bmask_c;

   assign wr_err_c  = !mapped_c || (hit_word_c && is_ro_c) ||
                      (hit_action_c && reg_be_i[0] && (reg_wdata_i[1:0] == 2'b11));
   assign wr_ok_c   = reg_we_i && !wr_err_c;
   assign act_req_c = wr_ok_c && hit_action_c && reg_be_i[0] &&
                      ((reg_wdata_i[1:0] == 2'b01) || (reg_wdata_i[1:0] == 2'b10));

   // Action supervision: cnt_q counts cycles already spent outstanding
   assign busy_c     = (state_q != S_IDLE);
   assign waiting_c  = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_IDLE);
   assign tmo_hit_c  = (32'(cnt_q) + 32'd1) >= 32'(TimeoutCycles);
   assign done_set_c = (state_q == S_WAIT_IDLE) && action_idle_i;
   assign tmo_set_c  = waiting_c && tmo_hit_c && !done_set_c;
   assign ovr_set_c  = act_req_c && busy_c;
   assign cnt_inc_c  = (cnt_q == CW'(TimeoutCycles)) ? cnt_q : cnt_q + CW'(1);

   assign set_c = {status_i, ovr_set_c, tmo_set_c, done_set_c};
   assign clr_c = (wr_ok_c && hit_status_c) ? wmask_c[SW-1:0] : '0;

   always_comb begin
      rdata_c = '0;
      if (hit_status_c) rdata_c = 32'(status_q);
      if (hit_irqen_c)  rdata_c = 32'(irqen_q);
      if (hit_action_c) rdata_c = {30'b0, busy_c, action_idle_i};
      for (int unsigned i = 0; i < NumRw; i++) begin
         if (hit_word_c && (word_idx_c == 32'(i))) rdata_c = rw_q[i];
      end
      for (int unsigned j = 0; j < NumRo; j++) begin
         if (hit_word_c && (word_idx_c == 32'(NumRw + j))) rdata_c = ro_i[32*j +: 32];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         action_q <= 2'b00;
      end else begin
         action_q <= 2'b00;
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (act_req_c) begin
                  state_q  <= S_ISSUE;
                  action_q <= reg_wdata_i[1:0];
               end
            end
            S_ISSUE: begin
               cnt_q   <= cnt_inc_c;
               state_q <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (tmo_set_c) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_inc_c;
                  if (!action_idle_i) state_q <= S_WAIT_IDLE;
               end
            end
            S_WAIT_IDLE: begin
               if (done_set_c || tmo_set_c) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_inc_c;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Register file, sticky status (set beats clear) and read/error response
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NumRw; i++) rw_q[i] <= RwResetVal[32*i +: 32];
         status_q <= '0;
         irqen_q  <= '0;
         irq_q    <= 1'b0;
         rdata_q  <= '0;
         error_q  <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NumRw; i++) begin
            if (wr_ok_c && hit_word_c && (word_idx_c == 32'(i)))
               rw_q[i] <= (rw_q[i] & ~bmask_c) | wmask_c;
         end
         if (wr_ok_c && hit_irqen_c)
            irqen_q <= (irqen_q & ~bmask_c[SW-1:0]) | wmask_c[SW-1:0];
         status_q <= (status_q & ~clr_c) | set_c;
         irq_q    <= |(status_q & irqen_q);
         rdata_q  <= (reg_re_i && mapped_c) ? rdata_c : '0;
         error_q  <= (reg_re_i && !mapped_c) || (reg_we_i && wr_err_c);
      end
   end

   for (genvar g = 0; g < NumRw; g++) begin : g_rw
      assign rw_o[32*g +: 32] = rw_q[g];
   end

   assign reg_rdata_o = rdata_q;
   assign reg_error_o = error_q;
   assign irq_o       = irq_q;
   assign action_o    = action_q;

endmodule

// File: tb/tb_hr_csr_bank.sv
// Bench for hr_csr_bank: transaction-level reference model compared every
// cycle, plus directed sequences with hand-computed expectations.
module tb_hr_csr_bank;

   localparam int unsigned AW  = 7;
   localparam int unsigned NRW = 4;
   localparam int unsigned NRO = 4;
   localparam int unsigned NST = 4;
   localparam int unsigned TMO = 16;
   localparam int unsigned SW  = 3 + NST;
   localparam logic [NRW*32-1:0] RWRST =
      {32'hDEAD_0003, 32'hC0DE_0002, 32'hA5A5_0001, 32'h0000_0000};

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              we = 1'b0, re = 1'b0, idle = 1'b1;
   logic [AW-1:0]     addr = '0;
   logic [31:0]       wdata = '0;
   logic [3:0]        be = '0;
   logic [NST-1:0]    status = '0;
   logic [NRO*32-1:0] ro = '0;
   logic [31:0]       reg_rdata;
   logic              reg_error, irq;
   logic [NRW*32-1:0] rw;
   logic [1:0]        action;

   hr_csr_bank #(
      .AW(AW), .NumRw(NRW), .NumRo(NRO), .NumStatus(NST),
      .RwResetVal(RWRST), .TimeoutCycles(TMO)
   ) dut (
      .clk_i(clk), .rst_i(rst), .reg_we_i(we), .reg_re_i(re),
      .reg_addr_i(addr), .reg_wdata_i(wdata), .reg_be_i(be),
      .reg_rdata_o(reg_rdata), .reg_error_o(reg_error), .rw_o(rw),
      .ro_i(ro), .status_i(status), .irq_o(irq), .action_o(action),
      .action_idle_i(idle)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: state after each edge
   logic [31:0]   m_rw [NRW];
   logic [SW-1:0] m_status, m_irqen, m_clr;
   logic          m_irq, m_err;
   logic [31:0]   m_rdata, m_bm, m_wm;
   logic [1:0]    m_action;
   bit            m_active, m_seen_low, m_was_active, m_done, m_tmo, m_ovr, m_werr, m_wok, m_req;
   int            m_age, m_kind, m_idx;
   logic [127:0]  m_rw_flat;

   // -1 unmapped, 0 STATUS, 1 IRQ_EN, 2 ACTION, 3 RW word, 4 RO word
   function automatic int kind(input logic [AW-1:0] a);
      int ai;
      ai = int'(a);
      if (ai % 4 != 0) return -1;
      if (ai == 0) return 0;
      if (ai == 4) return 1;
      if (ai == 8) return 2;
      if (ai >= 16 && ai < 16 + 4 * int'(NRW + NRO)) return ((ai - 16) / 4 < int'(NRW)) ? 3 : 4;
      return -1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NRW); i++) m_rw[i] = RWRST[32*i +: 32];
         m_status = '0; m_irqen = '0; m_irq = 1'b0; m_err = 1'b0;
         m_rdata = '0; m_action = 2'b00; m_active = 0; m_seen_low = 0; m_age = 0;
      end else begin
         m_irq  = |(m_status & m_irqen);
         m_kind = kind(addr);
         m_idx  = (int'(addr) - 16) / 4;
         m_bm   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
         m_wm   = wdata & m_bm;
         m_rdata = '0;
         if (re) begin
            case (m_kind)
               0: m_rdata = 32'(m_status);
               1: m_rdata = 32'(m_irqen);
               2: m_rdata = {30'b0, m_active, idle};
               3: m_rdata = m_rw[m_idx];
               4: m_rdata = ro[32*(m_idx - int'(NRW)) +: 32];
               default: m_rdata = '0;
            endcase
         end
         m_werr = we && (m_kind < 0 || m_kind == 4 ||
                         (m_kind == 2 && be[0] && wdata[1:0] == 2'b11));
         m_err  = (re && m_kind < 0) || m_werr;
         m_wok  = we && !m_werr;
         // Outstanding action: m_age = cycles outstanding including this one
         m_was_active = m_active;
         m_done = 0; m_tmo = 0;
         if (m_active) begin
            m_age++;
            if (m_age > 1) begin
               if (m_seen_low && idle)        m_done = 1;
               else if (m_age >= int'(TMO))   m_tmo = 1;
               else if (!idle)                m_seen_low = 1;
            end
            if (m_done || m_tmo) m_active = 0;
         end
         m_action = 2'b00;
         m_ovr = 0;
         m_req = m_wok && m_kind == 2 && be[0] && (wdata[1:0] == 2'b01 || wdata[1:0] == 2'b10);
         if (m_req) begin
            if (m_was_active) m_ovr = 1;
            else begin
               m_active = 1; m_age = 0; m_seen_low = 0; m_action = wdata[1:0];
            end
         end
         m_clr    = (m_wok && m_kind == 0) ? m_wm[SW-1:0] : '0;
         m_status = (m_status & ~m_clr) | {status, m_ovr, m_tmo, m_done};
         if (m_wok && m_kind == 1) m_irqen = (m_irqen & ~m_bm[SW-1:0]) | m_wm[SW-1:0];
         if (m_wok && m_kind == 3) m_rw[m_idx] = (m_rw[m_idx] & ~m_bm) | m_wm;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < int'(NRW); i++) m_rw_flat[32*i +: 32] = m_rw[i];
      check("mdl_rdata",  128'(reg_rdata), 128'(m_rdata));
      check("mdl_error",  128'(reg_error), 128'(m_err));
      check("mdl_irq",    128'(irq),       128'(m_irq));
      check("mdl_action", 128'(action),    128'(m_action));
      check("mdl_rw",     128'(rw),        m_rw_flat);
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_cyc();
      we = 1'b0; re = 1'b0;
      cyc();
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] dt, input logic [3:0] b);
      addr = a; wdata = dt; be = b; we = 1'b1; re = 1'b0;
      cyc();
      we = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a, output logic [31:0] dt, output logic er);
      addr = a; re = 1'b1; we = 1'b0;
      cyc();
      dt = reg_rdata; er = reg_error;
      re = 1'b0;
   endtask

   logic [31:0]  d;
   logic         e;
   logic [127:0] exp_rw;
   logic [AW-1:0] alist [16] = '{7'h00, 7'h04, 7'h08, 7'h08, 7'h08, 7'h0C, 7'h10, 7'h14,
                                 7'h18, 7'h1C, 7'h20, 7'h24, 7'h2C, 7'h30, 7'h01, 7'h7C};
   int mode;

   initial begin
      ro = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
      repeat (2) cyc();
      check("rst_rw", 128'(rw), 128'(RWRST));
      check("rst_irq", 128'(irq), 128'(0));
      check("rst_action", 128'(action), 128'(0));
      check("rst_rdata", 128'(reg_rdata), 128'(0));
      check("rst_error", 128'(reg_error), 128'(0));
      rst = 1'b0;

      // RW word reset value and byte-masked write
      rd(7'h10, d, e); check("rd_w0_rst", 128'(d), 128'(0));
      rd(7'h14, d, e); check("rd_w1_rst", 128'(d), 128'(32'hA5A5_0001));
      wr(7'h10, 32'h1234_5678, 4'b0101);
      check("rw_o_w0", 128'(rw[31:0]), 128'(32'h0034_0078));
      rd(7'h10, d, e); check("rd_w0_wr", 128'(d), 128'(32'h0034_0078));

      // Sticky status, irq latency, W1C while source high
      wr(7'h04, 32'h8, 4'hF);
      status = 4'b0001; cyc(); status = '0;
      check("irq_plus1", 128'(irq), 128'(0));
      cyc();
      check("irq_plus2", 128'(irq), 128'(1));
      rd(7'h00, d, e); check("status_sticky", 128'(d), 128'(32'h8));
      status = 4'b0001; wr(7'h00, 32'h8, 4'hF); status = '0;
      rd(7'h00, d, e); check("w1c_set_wins", 128'(d), 128'(32'h8));
      wr(7'h00, 32'h8, 4'hF);
      rd(7'h00, d, e); check("w1c_clear", 128'(d), 128'(0));
      check("irq_fall", 128'(irq), 128'(0));

      // Action completes normally
      wr(7'h08, 32'h1, 4'hF);
      check("act_strobe_wr", 128'(action), 128'(2'b01));
      idle = 1'b0;
      rd(7'h08, d, e); check("act_busy_rd", 128'(d), 128'(32'h2));
      check("act_one_cycle", 128'(action), 128'(0));
      repeat (4) idle_cyc();
      idle = 1'b1; idle_cyc();
      rd(7'h00, d, e); check("act_done", 128'(d), 128'(32'h1));
      wr(7'h00, 32'hFFFF_FFFF, 4'hF);

      // Action timeout with idle stuck high
      wr(7'h08, 32'h2, 4'hF);
      check("act_strobe_rd", 128'(action), 128'(2'b10));
      repeat (15) idle_cyc();
      rd(7'h08, d, e); check("tmo_last_busy", 128'(d), 128'(32'h3));
      rd(7'h00, d, e); check("tmo_status", 128'(d), 128'(32'h2));
      rd(7'h08, d, e); check("tmo_idle", 128'(d), 128'(32'h1));
      wr(7'h00, 32'hFFFF_FFFF, 4'hF);

      // Overrun and illegal action code
      wr(7'h08, 32'h1, 4'hF);
      wr(7'h08, 32'h2, 4'hF);
      check("ovr_no_strobe", 128'(action), 128'(0));
      idle = 1'b0; idle_cyc();
      idle = 1'b1; idle_cyc();
      rd(7'h00, d, e); check("ovr_status", 128'(d), 128'(32'h5));
      wr(7'h00, 32'hFFFF_FFFF, 4'hF);
      wr(7'h08, 32'h3, 4'hF);
      check("act11_err", 128'(reg_error), 128'(1));
      check("act11_no_strobe", 128'(action), 128'(0));

      // Access errors
      rd(7'h01, d, e); check("mis_err", 128'(e), 128'(1)); check("mis_data", 128'(d), 128'(0));
      rd(7'h0C, d, e); check("hole_err", 128'(e), 128'(1));
      rd(7'h30, d, e); check("past_end_err", 128'(e), 128'(1)); check("past_end_data", 128'(d), 128'(0));
      rd(7'h20, d, e); check("ro0_data", 128'(d), 128'(32'h1111_0001)); check("ro0_err", 128'(e), 128'(0));
      rd(7'h2C, d, e); check("ro3_data", 128'(d), 128'(32'h4444_0004));
      wr(7'h20, 32'hFFFF_FFFF, 4'hF);
      check("ro_wr_err", 128'(reg_error), 128'(1));
      exp_rw = 128'(RWRST);
      exp_rw[31:0] = 32'h0034_0078;
      check("ro_wr_rw", 128'(rw), exp_rw);

      // Reset while waiting for the controller to go idle again
      status = 4'b0001; idle_cyc(); status = '0;
      idle_cyc();
      check("irq_pre_rst", 128'(irq), 128'(1));
      wr(7'h08, 32'h1, 4'hF);
      idle = 1'b0; idle_cyc(); idle_cyc();
      rst = 1'b1; addr = 7'h00; re = 1'b1;
      cyc();
      re = 1'b0;
      check("mid_rst_rw", 128'(rw), 128'(RWRST));
      check("mid_rst_irq", 128'(irq), 128'(0));
      check("mid_rst_action", 128'(action), 128'(0));
      check("mid_rst_rdata", 128'(reg_rdata), 128'(0));
      check("mid_rst_err", 128'(reg_error), 128'(0));
      rst = 1'b0; idle = 1'b1;
      repeat (3) idle_cyc();
      rd(7'h00, d, e); check("mid_rst_status", 128'(d), 128'(0));
      rd(7'h04, d, e); check("mid_rst_irqen", 128'(d), 128'(0));

      // Randomized traffic against the model
      mode = 0;
      for (int n = 0; n < 3000; n++) begin
         if (n % 40 == 0) mode = int'($urandom_range(0, 2));
         case (mode)
            1:       idle = 1'b1;
            2:       idle = ($urandom_range(0, 5) == 0);
            default: idle = 1'($urandom_range(0, 1));
         endcase
         rst   = ($urandom_range(0, 399) == 0);
         we    = 1'($urandom_range(0, 1));
         re    = 1'($urandom_range(0, 1));
         addr  = alist[$urandom_range(0, 15)];
         if ($urandom_range(0, 7) == 0) addr = 7'($urandom);
         wdata = $urandom;
         be    = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
         for (int k = 0; k < int'(NST); k++) status[k] = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 49) == 0) ro = {$urandom, $urandom, $urandom, $urandom};
         cyc();
      end
      rst = 1'b0; we = 1'b0; re = 1'b0; status = '0;
      repeat (4) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
